dsd_ptmem: RTL
==============

Name: dsd_ptmem

Overview:
Bus responder (slave) for the page-table walk bus driven by the DSD paged MMU master port (va/lock/rdy/wr/sel/adr/dat).
Holds page directory/table words in a local 64-bit-wide synchronous RAM and answers walk reads and writes with a programmable number of wait states.
A second, lower-priority port (B) lets a loader or debug master initialise the tables. A locked MMU sequence always starves port B.
It sits beside the MPU top and connects to its madr/mdat/mva/mlock/mwr/msel/mrdy pins.

Parameters:
AWID, 10, word-address width; RAM depth = 2**AWID 64-bit words.
BASE, 48'h0000_0010_0000, byte base address; decode compares adr[47:AWID+3] with BASE[47:AWID+3].
WAIT_STATES, 1, extra cycles between request acceptance and rdy; range 0..15.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
va_i  in  1  A-port (MMU) valid memory address
lock_i  in  1  A-port bus lock; blocks port B while high
wr_i  in  1  A-port write enable
sel_i  in  8  A-port byte lane selects
adr_i  in  48  A-port byte address
dat_i  in  64  A-port write data
dat_o  out  64  A-port read data
rdy_o  out  1  A-port cycle complete
bva_i  in  1  B-port valid
bwr_i  in  1  B-port write enable
bsel_i  in  8  B-port byte lane selects
badr_i  in  48  B-port byte address
bdat_i  in  64  B-port write data
bdat_o  out  64  B-port read data
brdy_o  out  1  B-port cycle complete
err_o  out  1  one-cycle pulse with rdy/brdy when the completed access missed decode

Behaviour:
- Single clock clk_i; reset synchronous, active-high on rst_i. On reset: state=IDLE, rdy_o=0, brdy_o=0, err_o=0, dat_o=0, bdat_o=0, wait counter=0, lock-hold flag=0. RAM contents are not cleared.
- A reset asserted mid-cycle aborts the cycle. A write already committed to RAM stays committed. No rdy is issued.
- FSM states:
  - IDLE: evaluate requests, then go to WAIT. If WAIT_STATES=0, go directly to RD.
  - WAIT: count down WAIT_STATES cycles.
  - RD: RAM read data is valid at the end of this cycle.
  - ACK: rdy_o or brdy_o is high for exactly one cycle; return to IDLE.
- Arbitration in IDLE:
  - A wins if va_i=1.
  - Otherwise B wins if bva_i=1, lock_i=0 and the lock-hold flag=0.
- Lock-hold flag:
  - Set when A is granted with lock_i=1.
  - Cleared in IDLE when lock_i=0.
  - While set, B is not granted even if va_i is momentarily low between locked walk accesses.
- The granted port's adr, wr, sel and dat are latched at grant. The master must hold them until it samples rdy, but the block uses only the latched copy.
- Writes: the RAM word at adr[AWID+2:3] is updated per byte lane sel[i] on the cycle entering RD. Read data for a write cycle returns the post-write word.
- Reads: RAM is synchronous, one-cycle read latency. dat_o/bdat_o are registered and change only in ACK; they hold their value otherwise.
- Decode miss:
  - No RAM write.
  - Read data = 64'hFFFF_FFFF_FFFF_FFFF (MMU treats this as an invalid PTE).
  - err_o pulses with the rdy.
- Latency from the grant edge to the rdy-high cycle is WAIT_STATES+2 cycles. Back-to-back throughput is one access per WAIT_STATES+3 cycles, because IDLE needs one cycle after ACK.
- sel=0 write: completes normally and modifies nothing.
- Address bits [2:0] are ignored; lanes are chosen by sel only.

Decomposition:
- Shared package dsd_ptmem_pkg holds:
  - state enum IDLE/WAIT/RD/ACK;
  - the constant PTE_INVALID = all ones;
  - the port-select encoding PORT_A/PORT_B.
- One sub-module, dsd_ptmem_ram: a byte-lane-write, 64-bit, single-port synchronous RAM with parameter AWID, inferable as block RAM.

Test Plan:
- Reset then A write, adr=BASE+0x18, sel=8'hFF, dat=64'h0123_4567_89AB_CDEF, WAIT_STATES=1 -> rdy_o high exactly 3 cycles after the grant edge, one cycle wide. A following read of the same address returns 64'h0123_4567_89AB_CDEF.
- A write sel=8'h0F, dat=64'hFFFF_FFFF_1111_2222 over the previous word -> read back gives 64'h0123_4567_1111_2222.
- va_i and bva_i both asserted in IDLE -> A served first. brdy_o follows WAIT_STATES+3 cycles after rdy_o. B read data is correct.
- Locked walk: lock_i=1, two A reads with va_i low for 2 cycles between them, bva_i held high throughout -> brdy_o stays 0 until lock_i falls and the next IDLE is reached.
- A read at BASE + 2**(AWID+3) (out of range) -> dat_o=64'hFFFF_FFFF_FFFF_FFFF with err_o=1 in the rdy cycle. The RAM is unchanged.
- rst_i asserted during WAIT of an A read -> the next cycle has rdy_o=0 and state IDLE. A new read after reset completes normally with WAIT_STATES=0 latency of 2 cycles.

Source files
------------

// File: rtl/dsd_ptmem_pkg.sv
// Shared types and constants for the page-table walk memory responder.
package dsd_ptmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RD   = 2'd2,
        ST_ACK  = 2'd3
    } state_e;

    localparam logic [63:0] PTE_INVALID = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/dsd_ptmem_ram.sv
// Single-port 64-bit synchronous RAM with per-byte write enables.
// Read data is write-first: a write cycle returns the merged word.
module dsd_ptmem_ram
    import dsd_ptmem_pkg::*;
#(
    parameter int unsigned AWID = 10
) (
    input  logic            clk_i,
    input  logic            en_i,
    input  logic [7:0]      we_i,
    input  logic [AWID-1:0] addr_i,
    input  logic [63:0]     wdat_i,
    output logic [63:0]     rdat_o
);

    logic [63:0] mem_r [2**AWID];
    logic [63:0] rdat_r;

    // Byte-lane write with new-data-on-read behaviour for block RAM inference.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int i = 0; i < 8; i++) begin
                if (we_i[i]) begin
                    mem_r[addr_i][8*i +: 8] <= wdat_i[8*i +: 8];
                    rdat_r[8*i +: 8]        <= wdat_i[8*i +: 8];
                end else begin
                    rdat_r[8*i +: 8]        <= mem_r[addr_i][8*i +: 8];
                end
            end
        end
    end

    assign rdat_o = rdat_r;

endmodule

// File: rtl/dsd_ptmem.sv
// Page-table walk bus responder: MMU port A with lock, lower-priority loader port B,
// shared byte-lane RAM and a programmable number of wait states.
module dsd_ptmem
    import dsd_ptmem_pkg::*;
#(
    parameter int unsigned AWID        = 10,
    parameter logic [47:0] BASE        = 48'h0000_0010_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        va_i,
    input  logic        lock_i,
    input  logic        wr_i,
    input  logic [7:0]  sel_i,
    input  logic [47:0] adr_i,
    input  logic [63:0] dat_i,
    output logic [63:0] dat_o,
    output logic        rdy_o,
    input  logic        bva_i,
    input  logic        bwr_i,
    input  logic [7:0]  bsel_i,
    input  logic [47:0] badr_i,
    input  logic [63:0] bdat_i,
    output logic [63:0] bdat_o,
    output logic        brdy_o,
    output logic        err_o
);

    localparam logic [3:0] WS_M1 = (WAIT_STATES == 32'd0) ? 4'd0 : 4'(WAIT_STATES - 32'd1);

    function automatic logic decode_hit(input logic [47-AWID-3:0] tag);
        return tag == BASE[47:AWID+3];
    endfunction

    state_e      state_r, state_nx_s;
    logic        port_r, wr_r, hit_r, hold_r;
    logic [7:0]  sel_r;
    logic [47:0] adr_r;
    logic [63:0] dat_r;
    logic [3:0]  cnt_r;
    logic        rdy_r, brdy_r, err_r;
    logic [63:0] dat_o_r, bdat_o_r;

    logic        grant_a_s, grant_b_s, grant_s;
    logic        in_port_s, in_wr_s;
    logic [7:0]  in_sel_s;
    logic [47:0] in_adr_s;
    logic [63:0] in_dat_s;

    logic        ram_en_s, ram_wr_s;
    logic [7:0]  ram_sel_s, ram_we_s;
    logic [47:0] ram_adr_s;
    logic [63:0] ram_dat_s, ram_rdat_s, rd_word_s;
    logic        unused_s;

    // A always wins; B is starved by an active or held lock.
    assign grant_a_s = (state_r == ST_IDLE) && va_i;
    assign grant_b_s = (state_r == ST_IDLE) && !va_i && bva_i && !lock_i && !hold_r;
    assign grant_s   = grant_a_s || grant_b_s;

    // Select the request fields of the port being granted.
    always_comb begin
        in_port_s = PORT_A;
        in_wr_s   = wr_i;
        in_sel_s  = sel_i;
        in_adr_s  = adr_i;
        in_dat_s  = dat_i;
        if (grant_b_s) begin
            in_port_s = PORT_B;
            in_wr_s   = bwr_i;
            in_sel_s  = bsel_i;
            in_adr_s  = badr_i;
            in_dat_s  = bdat_i;
        end else begin
            in_port_s = PORT_A;
        end
    end

    // Next-state logic for the IDLE/WAIT/RD/ACK cycle sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nx_s = (WAIT_STATES == 32'd0) ? ST_RD : ST_WAIT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nx_s = ST_RD;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_RD:   state_nx_s = ST_ACK;
            ST_ACK:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // RAM is accessed on the edge entering RD; with no wait states the live request is used.
    always_comb begin
        ram_en_s  = 1'b0;
        ram_wr_s  = wr_r;
        ram_sel_s = sel_r;
        ram_adr_s = adr_r;
        ram_dat_s = dat_r;
        if ((state_r == ST_IDLE) && (state_nx_s == ST_RD)) begin
            ram_en_s  = 1'b1;
            ram_wr_s  = in_wr_s;
            ram_sel_s = in_sel_s;
            ram_adr_s = in_adr_s;
            ram_dat_s = in_dat_s;
        end else if ((state_r == ST_WAIT) && (state_nx_s == ST_RD)) begin
            ram_en_s  = 1'b1;
        end else begin
            ram_en_s  = 1'b0;
        end
        ram_we_s = (ram_wr_s && decode_hit(ram_adr_s[47:AWID+3])) ? ram_sel_s : 8'h00;
    end

    assign unused_s  = ^ram_adr_s[2:0];
    assign rd_word_s = hit_r ? ram_rdat_s : PTE_INVALID;

    dsd_ptmem_ram #(
        .AWID (AWID)
    ) u_ram (
        .clk_i  (clk_i),
        .en_i   (ram_en_s),
        .we_i   (ram_we_s),
        .addr_i (ram_adr_s[AWID+2:3]),
        .wdat_i (ram_dat_s),
        .rdat_o (ram_rdat_s)
    );

    // Request capture, wait counting, lock-hold tracking and registered responses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            port_r   <= PORT_A;
            wr_r     <= 1'b0;
            sel_r    <= 8'h00;
            adr_r    <= 48'h0;
            dat_r    <= 64'h0;
            hit_r    <= 1'b0;
            cnt_r    <= 4'd0;
            hold_r   <= 1'b0;
            rdy_r    <= 1'b0;
            brdy_r   <= 1'b0;
            err_r    <= 1'b0;
            dat_o_r  <= 64'h0;
            bdat_o_r <= 64'h0;
        end else begin
            state_r <= state_nx_s;
            rdy_r   <= 1'b0;
            brdy_r  <= 1'b0;
            err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        port_r <= in_port_s;
                        wr_r   <= in_wr_s;
                        sel_r  <= in_sel_s;
                        adr_r  <= in_adr_s;
                        dat_r  <= in_dat_s;
                        hit_r  <= decode_hit(in_adr_s[47:AWID+3]);
                        cnt_r  <= WS_M1;
                    end
                    // The hold keeps B out across the gaps of a locked walk.
                    if (grant_a_s) begin
                        hold_r <= lock_i;
                    end else if (!lock_i) begin
                        hold_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RD: begin
                    if (port_r == PORT_A) begin
                        rdy_r   <= 1'b1;
                        dat_o_r <= rd_word_s;
                    end else begin
                        brdy_r   <= 1'b1;
                        bdat_o_r <= rd_word_s;
                    end
                    err_r <= !hit_r;
                end
                default: begin
                end
            endcase
        end
    end

    assign dat_o  = dat_o_r;
    assign rdy_o  = rdy_r;
    assign bdat_o = bdat_o_r;
    assign brdy_o = brdy_r;
    assign err_o  = err_r;

endmodule
